// File: rtl/cwe1262_lock_reader_pkg.sv
// Shared types and default sizes for the lockable register bank read-side responder.
package cwe1262_pkg;

    localparam int NREGS_DEF = 4;
    localparam int DW_DEF    = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rd_state_e;

    // One buffered response: error flag plus the (possibly zeroed) read data.
    typedef struct packed {
        logic              err;
        logic [DW_DEF-1:0] data;
    } rsp_t;

endpackage

// File: rtl/cwe1262_lock_reader_if.sv
// Read request / response handshake bundle between a bus requester and the lock reader.
interface cwe1262_lock_reader_if #(
    parameter int AW = 2,
    parameter int DW = 32
);
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_priv;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output rd_valid, rd_addr, rd_priv, rsp_ready,
        input  rd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  rd_valid, rd_addr, rd_priv, rsp_ready,
        output rd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/cwe1262_lock_reader_sat_cnt.sv
// Saturating up-counter: steps by one per enabled cycle and sticks at all-ones.
module cwe1262_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/cwe1262_lock_reader.sv
// Read-side responder for a lockable register bank: one sticky lock denies every index
// to unprivileged readers; one-deep response buffer sustains one read per cycle.
module cwe1262_lock_reader
    import cwe1262_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = 2,
    parameter int ERRW  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREGS*DW-1:0]   bank_flat,
    input  logic                  lock_set,
    cwe1262_lock_reader_if.slave  bus,
    output logic                  locked,
    output logic [ERRW-1:0]       err_cnt
);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    if (DW != DW_DEF) begin : g_dw_check
        $error("cwe1262_lock_reader: DW must equal the package response width");
    end
    if ((1 << AW) < NREGS) begin : g_aw_check
        $error("cwe1262_lock_reader: AW too narrow to address NREGS entries");
    end

    rd_state_e     state_q;
    rsp_t          rsp_q;
    rsp_t          rsp_d;
    logic          locked_q;
    logic          lock_eff;
    logic          in_range;
    logic          accept;
    logic          rd_ready;
    logic [DW-1:0] sel_data;
    logic [DW-1:0] entry [NREGS];

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_unpack
        assign entry[gi] = bank_flat[gi*DW +: DW];
    end

    // A set pulse in the same cycle as a request already governs that request.
    assign lock_eff = locked_q | lock_set;
    assign in_range = ({1'b0, bus.rd_addr} < NREGS_W);
    assign rd_ready = (state_q == EMPTY) | bus.rsp_ready;
    assign accept   = bus.rd_valid & rd_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.rd_addr == AW'(i)) begin
                sel_data = entry[i];
            end
        end
    end

    // Data is forced to zero on any error so nothing leaks through a denied read.
    always_comb begin
        rsp_d.err  = ~in_range | (lock_eff & ~bus.rd_priv);
        rsp_d.data = rsp_d.err ? '0 : sel_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rsp_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            if (lock_set) begin
                locked_q <= 1'b1;
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                        rsp_q   <= rsp_d;
                    end
                end
                FULL: begin
                    if (accept) begin
                        rsp_q <= rsp_d;
                    end else if (bus.rsp_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    cwe1262_sat_cnt #(.W(ERRW)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept & rsp_d.err),
        .count (err_cnt)
    );

    assign bus.rd_ready  = rd_ready;
    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_data  = rsp_q.data;
    assign bus.rsp_err   = rsp_q.err;
    assign locked        = locked_q;
endmodule

// File: tb/tb_cwe1262_lock_reader.sv
// Bench for cwe1262_lock_reader: vector table plus scoreboard queue, and a second
// instance (3 entries, 2-bit counter) for saturation and out-of-range reads.
module tb_cwe1262_lock_reader;
    import cwe1262_pkg::*;

    localparam int NREGS = 4;
    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int ERRW  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                lock_set;
    logic                lock_set2;
    logic [DW-1:0]       bank  [NREGS];
    logic [DW-1:0]       bank2 [3];
    logic [NREGS*DW-1:0] bank_flat;
    logic [3*DW-1:0]     bank2_flat;
    logic                locked;
    logic                locked2;
    logic [ERRW-1:0]     err_cnt;
    logic [1:0]          err_cnt2;

    assign bank_flat  = {bank[3], bank[2], bank[1], bank[0]};
    assign bank2_flat = {bank2[2], bank2[1], bank2[0]};

    cwe1262_lock_reader_if #(.AW(AW), .DW(DW)) bus  ();
    cwe1262_lock_reader_if #(.AW(AW), .DW(DW)) bus2 ();

    cwe1262_lock_reader #(.NREGS(NREGS), .DW(DW), .AW(AW), .ERRW(ERRW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bank_flat (bank_flat),
        .lock_set  (lock_set),
        .bus       (bus),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    cwe1262_lock_reader #(.NREGS(3), .DW(DW), .AW(AW), .ERRW(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bank_flat (bank2_flat),
        .lock_set  (lock_set2),
        .bus       (bus2),
        .locked    (locked2),
        .err_cnt   (err_cnt2)
    );

    typedef struct {
        logic          valid;
        logic [AW-1:0] addr;
        logic          priv;
        logic          lset;
        logic          exp_err;
        logic [DW-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_pass  = 0;
    int            n_total = 0;
    logic          m_valid;
    logic          m_locked;
    int            m_cnt;
    logic          cur_err;
    logic [DW-1:0] cur_data;
    vec_t          tbl [13];
    logic [DW-1:0] a_val [NREGS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // One cycle: compare at the falling edge, advance the model, then step past the rising edge.
    task automatic tick();
        exp_t e;
        logic acc;
        @(negedge clk);
        check("rd_ready", bus.rd_ready, !m_valid | bus.rsp_ready);
        check("rsp_valid", bus.rsp_valid, m_valid);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard: response with nothing expected, got data 0x%0h", bus.rsp_data);
            end else begin
                check("rsp_err", bus.rsp_err, exp_q[0].err);
                check("rsp_data", bus.rsp_data, exp_q[0].data);
            end
        end
        check("locked", locked, m_locked);
        check("err_cnt", err_cnt, m_cnt);
        acc = bus.rd_valid & (!m_valid | bus.rsp_ready);
        if (m_valid && bus.rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            e.err  = cur_err;
            e.data = cur_data;
            exp_q.push_back(e);
            if (cur_err && m_cnt < 255) m_cnt++;
        end
        m_valid  = acc | (m_valid & !bus.rsp_ready);
        m_locked = m_locked | lock_set;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.rd_valid = v.valid;
        bus.rd_addr  = v.addr;
        bus.rd_priv  = v.priv;
        lock_set     = v.lset;
        cur_err      = v.exp_err;
        cur_data     = v.exp_data;
        tick();
    endtask

    task automatic idle();
        bus.rd_valid = 1'b0;
        lock_set     = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        bus.rd_valid = 1'b0;
        lock_set     = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rd_ready", bus.rd_ready, 1);
        bus.rsp_ready = 1'b1;
        exp_q.delete();
        m_valid  = 1'b0;
        m_locked = 1'b0;
        m_cnt    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic d2_read(input logic [AW-1:0] addr, input logic priv, input logic lset,
                           input logic exp_err, input logic [DW-1:0] exp_data,
                           input logic [1:0] exp_cnt);
        bus2.rd_valid = 1'b1;
        bus2.rd_addr  = addr;
        bus2.rd_priv  = priv;
        lock_set2     = lset;
        @(posedge clk);
        #1;
        check("d2_rsp_valid", bus2.rsp_valid, 1);
        check("d2_rsp_err", bus2.rsp_err, exp_err);
        check("d2_rsp_data", bus2.rsp_data, exp_data);
        check("d2_err_cnt", err_cnt2, exp_cnt);
        $display("d2 read addr=%0d priv=%0d -> err=%0d data=0x%0h cnt=%0d",
                 addr, priv, bus2.rsp_err, bus2.rsp_data, err_cnt2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        a_val[0] = 32'hA0A0_0000;
        a_val[1] = 32'hA1A1_1111;
        a_val[2] = 32'hA2A2_2222;
        a_val[3] = 32'hA3A3_3333;
        for (int i = 0; i < NREGS; i++) bank[i] = a_val[i];
        bank2[0] = 32'hB000_0000;
        bank2[1] = 32'hB111_1111;
        bank2[2] = 32'hB222_2222;
        bus.rd_addr    = '0;
        bus.rd_priv    = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus2.rd_valid  = 1'b0;
        bus2.rd_addr   = '0;
        bus2.rd_priv   = 1'b0;
        bus2.rsp_ready = 1'b1;
        lock_set2      = 1'b0;
        cur_err        = 1'b0;
        cur_data       = '0;

        // Plain reads, lock pulse, denied reads, privileged reads.
        for (int i = 0; i < 4; i++) begin
            tbl[i]     = '{1'b1, AW'(i), 1'b0, 1'b0, 1'b0, a_val[i]};
            tbl[5 + i] = '{1'b1, AW'(i), 1'b0, 1'b0, 1'b1, 32'h0};
            tbl[9 + i] = '{1'b1, AW'(i), 1'b1, 1'b0, 1'b0, a_val[i]};
        end
        tbl[4] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i]);
            $display("vec %0d: valid=%0d addr=%0d priv=%0d lset=%0d exp_err=%0d exp_data=0x%0h",
                     i, tbl[i].valid, tbl[i].addr, tbl[i].priv, tbl[i].lset,
                     tbl[i].exp_err, tbl[i].exp_data);
        end
        idle();
        check("err_cnt_after_denied", err_cnt, 4);

        // Lock set in the same cycle as an unprivileged read.
        do_reset();
        apply('{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 32'h0});
        idle();
        check("locked_after_same_cycle_set", locked, 1);
        $display("same-cycle lock: locked=%0d err_cnt=%0d", locked, err_cnt);

        // Backpressure: pending response holds while the bank changes underneath.
        do_reset();
        bank[1] = 32'h1234_5678;
        bus.rsp_ready = 1'b0;
        apply('{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h1234_5678});
        bank[1]  = 32'hDEAD_BEEF;
        cur_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) tick();
        bus.rsp_ready = 1'b1;
        tick();
        idle();
        idle();
        $display("backpressure: final rsp_data=0x%0h", bus.rsp_data);
        bank[1] = a_val[1];

        // Reset while a locked, denied response is pending.
        do_reset();
        bus.rsp_ready = 1'b0;
        apply('{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 32'h0});
        check("pre_rst_rsp_valid", bus.rsp_valid, 1);
        check("pre_rst_locked", locked, 1);
        do_reset();
        apply('{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, a_val[0]});
        idle();
        idle();
        $display("post-reset read: rsp_data=0x%0h locked=%0d", bus.rsp_data, locked);

        // Narrow counter saturation and out-of-range addressing on the 3-entry instance.
        check("d2_err_cnt_init", err_cnt2, 0);
        d2_read(2'd0, 1'b0, 1'b1, 1'b1, 32'h0, 2'd1);
        lock_set2 = 1'b0;
        d2_read(2'd1, 1'b0, 1'b0, 1'b1, 32'h0, 2'd2);
        d2_read(2'd2, 1'b0, 1'b0, 1'b1, 32'h0, 2'd3);
        d2_read(2'd0, 1'b0, 1'b0, 1'b1, 32'h0, 2'd3);
        d2_read(2'd1, 1'b0, 1'b0, 1'b1, 32'h0, 2'd3);
        d2_read(2'd2, 1'b1, 1'b0, 1'b0, 32'hB222_2222, 2'd3);
        d2_read(2'd3, 1'b1, 1'b0, 1'b1, 32'h0, 2'd3);
        bus2.rd_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cwe1262_lock_reader.md
Name: cwe1262_lock_reader

Overview:
Read-side responder for a memory-mapped lockable register bank of NREGS entries. It accepts read requests over a valid/ready handshake and samples the bank contents supplied by the write-side bank. It returns data or an error over a valid/ready response channel.
A single sticky lock gates every register index identically, so there is no per-index lock selection. It sits between the bus read port and the bank storage.

Parameters:
NREGS, 4, number of bank registers
DW, 32, register data width
AW, 2, request address width (must satisfy 2**AW >= NREGS)
ERRW, 8, width of the denied-read counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
bank_flat  in  NREGS*DW  bank contents, entry i at bits [i*DW +: DW]
lock_set  in  1  set pulse for the sticky read lock
rd_valid  in  1  request valid
rd_ready  out  1  request ready
rd_addr  in  AW  register index
rd_priv  in  1  1 = privileged requester
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted by consumer
rsp_data  out  DW  read data (0 on error)
rsp_err  out  1  1 = read denied or address out of range
locked  out  1  current sticky lock state
err_cnt  out  ERRW  saturating count of error responses

Behaviour:
- Reset (async, rst_n=0): locked=0, rsp_valid=0, rsp_data=0, rsp_err=0, err_cnt=0, FSM=EMPTY. rd_ready follows its equation, so it is 1 while in reset.
- Sticky lock:
  - locked is set at a clock edge when lock_set=1.
  - locked clears only on reset; no software path clears it.
  - Effective lock is lock_eff = locked | lock_set, so a set arriving in the same cycle as a request already applies to that request.
- Address decode: rd_addr >= NREGS produces an error regardless of priv or lock.
- Access rule, identical for every index 0..NREGS-1:
  - Denied when lock_eff=1 and rd_priv=0.
  - Otherwise allowed.
- Handshake:
  - rd_ready = !rsp_valid | rsp_ready (combinational).
  - A request is accepted on an edge where rd_valid & rd_ready.
- Latency: the response is valid on the cycle after acceptance. bank_flat and the lock are sampled at the accepting edge; later bank changes do not alter a pending response.
- Response content:
  - Allowed read: rsp_err=0, rsp_data = selected entry.
  - Error (denied or out of range): rsp_err=1, rsp_data=0. Data never leaks on error.
- FSM with 2 states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no new accept.
  - FULL -> FULL on rsp_ready with a simultaneous accept (back-to-back, 1 read per cycle sustained).
- Hold rule: while rsp_valid & !rsp_ready, rsp_data, rsp_err and rsp_valid stay stable and rd_ready=0.
- err_cnt:
  - Increments by 1 at each accepting edge whose response is an error.
  - Saturates at 2**ERRW-1.
  - Never wraps.
- Reset mid-operation: any pending response is dropped immediately; the lock reopens and err_cnt returns to 0.
- rd_valid=0 gives no state change except lock sampling.

Decomposition:
- Package cwe1262_pkg holds:
  - enum rd_state_e {EMPTY, FULL}
  - typedef rsp_t {logic err; logic [DW-1:0] data}
  - localparam defaults for NREGS and DW
- Sub-module cwe1262_sat_cnt: parameterised saturating counter (en, count) used for err_cnt.

Test Plan:
1. Reset, bank={A0,A1,A2,A3}, unprivileged reads of addr 0..3 back-to-back with rsp_ready=1 -> rsp_valid each cycle after accept, data A0..A3, rsp_err=0, err_cnt=0.
2. Pulse lock_set, then unprivileged reads of addr 0, 1, 2, 3 -> all four give rsp_err=1, data=0, err_cnt=4. Privileged reads of the same addresses -> correct data, err=0. This checks that the lock is uniform across all indices.
3. lock_set=1 in the same cycle as an accepted unprivileged read of addr 2 -> that response has err=1, data=0, and locked=1 on the next cycle.
4. Backpressure: accept read of addr 1 (data 0x1234_5678), rsp_ready=0 for 3 cycles while bank[1] changes to 0xDEAD_BEEF -> rd_ready=0, response held at 0x1234_5678. Raising rsp_ready with rd_valid still high -> next accept occurs on the same edge.
5. ERRW=2, 5 denied reads -> err_cnt goes 1, 2, 3, 3, 3 (saturates, no wrap).
6. Assert rst_n=0 while rsp_valid=1 and locked=1 -> rsp_valid=0 and locked=0 immediately. After release, an unprivileged read of addr 0 returns data with err=0.
